// File: rtl/touch_filter.sv
// touch_filter
//   Conditions raw touchscreen ADC samples before they reach the painter.
//   Samples are collected in bursts of N_AVG; a burst whose per-axis spread
//   (max - min) exceeds MAX_SPREAD is thrown away, otherwise its truncated
//   average is published with a one-cycle pos_ready pulse. A pen-up timer
//   drops pen_down (and any partial burst) once the ADC has been silent for
//   PENUP_TIMEOUT cycles.
//
// Ports
//   clk        system clock
//   reset      synchronous, active-high reset
//   en         filter enable; low flushes the burst and drops pen_down
//   raw_ready  one-cycle strobe, raw_x/raw_y valid
//   raw_x/y    12-bit raw ADC conversions
//   pos_ready  one-cycle pulse, x_pos/y_pos hold a new averaged position
//   x_pos/y_pos averaged position, held until the next accepted burst
//   pen_down   pen contact flag
module touch_filter #(
  parameter int unsigned N_AVG         = 4,
  parameter logic [11:0] MAX_SPREAD    = 12'd64,
  parameter logic [23:0] PENUP_TIMEOUT = 24'd500000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        raw_ready,
  input  logic [11:0] raw_x,
  input  logic [11:0] raw_y,
  output logic        pos_ready,
  output logic [11:0] x_pos,
  output logic [11:0] y_pos,
  output logic        pen_down
);

  localparam int unsigned LOG2  = $clog2(N_AVG);
  localparam int unsigned SW    = 12 + LOG2;   // sum width; N_AVG samples cannot overflow it
  localparam logic [4:0]  N_CNT = 5'(N_AVG);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    CHECK  = 2'd2,
    OUTPUT = 2'd3
  } state_t;

  state_t         state_r;
  logic [SW-1:0]  x_sum_r, y_sum_r;
  logic [11:0]    x_min_r, x_max_r, y_min_r, y_max_r;
  logic [4:0]     cnt_r;
  logic [23:0]    timer_r;

  logic           sample_s;
  logic           timeout_s;
  logic [4:0]     cnt_inc_s;
  logic [11:0]    x_spread_s, y_spread_s;
  logic           spread_ok_s;

  assign sample_s    = raw_ready & en;
  assign timeout_s   = (timer_r == PENUP_TIMEOUT);
  assign cnt_inc_s   = cnt_r + 5'd1;
  assign x_spread_s  = x_max_r - x_min_r;
  assign y_spread_s  = y_max_r - y_min_r;
  assign spread_ok_s = (x_spread_s <= MAX_SPREAD) && (y_spread_s <= MAX_SPREAD);

  // Pen-up timer: cleared by every accepted strobe, saturates at the timeout.
  always_ff @(posedge clk) begin
    if (reset) begin
      timer_r <= 24'd0;
    end else if (sample_s) begin
      timer_r <= 24'd0;
    end else if (!timeout_s) begin
      timer_r <= timer_r + 24'd1;
    end else begin
      timer_r <= timer_r;
    end
  end

  // Burst FSM with accumulators and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      x_sum_r   <= '0;
      y_sum_r   <= '0;
      x_min_r   <= 12'd0;
      x_max_r   <= 12'd0;
      y_min_r   <= 12'd0;
      y_max_r   <= 12'd0;
      cnt_r     <= 5'd0;
      pos_ready <= 1'b0;
      pen_down  <= 1'b0;
      x_pos     <= 12'd0;
      y_pos     <= 12'd0;
    end else if (!en) begin
      // Flush: drop the burst and the pen, but keep the last position.
      state_r   <= IDLE;
      x_sum_r   <= '0;
      y_sum_r   <= '0;
      x_min_r   <= 12'd0;
      x_max_r   <= 12'd0;
      y_min_r   <= 12'd0;
      y_max_r   <= 12'd0;
      cnt_r     <= 5'd0;
      pos_ready <= 1'b0;
      pen_down  <= 1'b0;
    end else begin
      pos_ready <= 1'b0;
      if (timeout_s) begin
        pen_down <= 1'b0;
      end
      case (state_r)
        IDLE: begin
          if (raw_ready) begin
            x_sum_r <= SW'(raw_x);
            y_sum_r <= SW'(raw_y);
            x_min_r <= raw_x;
            x_max_r <= raw_x;
            y_min_r <= raw_y;
            y_max_r <= raw_y;
            cnt_r   <= 5'd1;
            state_r <= (N_CNT == 5'd1) ? CHECK : ACCUM;
          end
        end
        ACCUM: begin
          // A strobe coinciding with the timeout still counts.
          if (raw_ready) begin
            x_sum_r <= x_sum_r + SW'(raw_x);
            y_sum_r <= y_sum_r + SW'(raw_y);
            x_min_r <= (raw_x < x_min_r) ? raw_x : x_min_r;
            x_max_r <= (raw_x > x_max_r) ? raw_x : x_max_r;
            y_min_r <= (raw_y < y_min_r) ? raw_y : y_min_r;
            y_max_r <= (raw_y > y_max_r) ? raw_y : y_max_r;
            cnt_r   <= cnt_inc_s;
            if (cnt_inc_s == N_CNT) begin
              state_r <= CHECK;
            end
          end else if (timeout_s) begin
            x_sum_r <= '0;
            y_sum_r <= '0;
            cnt_r   <= 5'd0;
            state_r <= IDLE;
          end
        end
        CHECK: begin
          // Position and pen_down are loaded here so they are valid together
          // with pos_ready in the OUTPUT cycle.
          if (spread_ok_s) begin
            x_pos     <= x_sum_r[SW-1:LOG2];
            y_pos     <= y_sum_r[SW-1:LOG2];
            pos_ready <= 1'b1;
            pen_down  <= 1'b1;
            state_r   <= OUTPUT;
          end else begin
            state_r   <= IDLE;
          end
          x_sum_r <= '0;
          y_sum_r <= '0;
          cnt_r   <= 5'd0;
        end
        OUTPUT: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_touch_filter.sv
// Scoreboard bench for touch_filter: directed bursts push expected positions
// (with the cycle the pulse must appear in); a monitor pops them on pos_ready.
module tb_touch_filter;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic        raw_ready;
  logic [11:0] raw_x, raw_y;
  logic        pos_ready;
  logic [11:0] x_pos, y_pos;
  logic        pen_down;

  typedef struct packed {
    logic [11:0] x;
    logic [11:0] y;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   last_cyc = 0;
  logic prev_pr  = 1'b0;

  touch_filter #(
    .N_AVG(4),
    .MAX_SPREAD(12'd64),
    .PENUP_TIMEOUT(24'd40)
  ) dut (
    .clk(clk),
    .reset(reset),
    .en(en),
    .raw_ready(raw_ready),
    .raw_x(raw_x),
    .raw_y(raw_y),
    .pos_ready(pos_ready),
    .x_pos(x_pos),
    .y_pos(y_pos),
    .pen_down(pen_down)
  );

  always #5 clk = ~clk;

  // Cycle counter used to time expected pulses.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic send(input logic [11:0] x, input logic [11:0] y, input int idle_n);
    @(negedge clk);
    raw_ready = 1'b1;
    raw_x     = x;
    raw_y     = y;
    last_cyc  = cyc;
    repeat (idle_n) begin
      @(negedge clk);
      raw_ready = 1'b0;
    end
  endtask

  task automatic expect_pos(input logic [11:0] x, input logic [11:0] y);
    exp_t e;
    e.x   = x;
    e.y   = y;
    e.cyc = last_cyc + 2;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: every pulse must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (pos_ready) begin
      check("pulse_twice", 32'(prev_pr), 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("x_pos", 32'(x_pos), 32'(e.x));
        check("y_pos", 32'(y_pos), 32'(e.y));
        check("pulse_cycle", 32'(cyc), 32'(e.cyc));
        check("pen_at_pulse", 32'(pen_down), 32'd1);
      end
    end
    prev_pr <= pos_ready;
  end

  initial begin
    reset = 1'b1; en = 1'b1; raw_ready = 1'b0; raw_x = 12'd0; raw_y = 12'd0;
    idle(3);
    check("rst_pos_ready", 32'(pos_ready), 32'd0);
    check("rst_pen_down", 32'(pen_down), 32'd0);
    check("rst_x_pos", 32'(x_pos), 32'd0);
    check("rst_y_pos", 32'(y_pos), 32'd0);
    reset = 1'b0;
    idle(2);

    // Identical samples, spaced out.
    send(12'd100, 12'd200, 3);
    send(12'd100, 12'd200, 3);
    send(12'd100, 12'd200, 3);
    send(12'd100, 12'd200, 1);
    expect_pos(12'd100, 12'd200);
    check("pen_before_first", 32'(pen_down), 32'd0);
    idle(4);

    // Averaging with truncation, back-to-back strobes.
    send(12'd100, 12'd50, 0);
    send(12'd102, 12'd50, 0);
    send(12'd104, 12'd51, 0);
    send(12'd106, 12'd51, 1);
    expect_pos(12'd103, 12'd50);
    idle(4);

    // Spread exactly at the limit is accepted.
    send(12'd0, 12'd10, 1);
    send(12'd0, 12'd10, 1);
    send(12'd0, 12'd10, 1);
    send(12'd64, 12'd10, 1);
    expect_pos(12'd16, 12'd10);
    idle(4);
    // One over the limit on X, then on Y: both rejected.
    send(12'd0, 12'd10, 1);
    send(12'd0, 12'd10, 1);
    send(12'd0, 12'd10, 1);
    send(12'd65, 12'd10, 1);
    idle(3);
    send(12'd5, 12'd0, 1);
    send(12'd5, 12'd0, 1);
    send(12'd5, 12'd0, 1);
    send(12'd5, 12'd65, 1);
    idle(4);
    check("retain_x", 32'(x_pos), 32'd16);
    check("retain_y", 32'(y_pos), 32'd10);

    // Pen-up timeout discards a partial burst.
    send(12'd500, 12'd500, 1);
    send(12'd500, 12'd500, 1);
    idle(30);
    check("pen_before_timeout", 32'(pen_down), 32'd1);
    idle(15);
    check("pen_after_timeout", 32'(pen_down), 32'd0);
    send(12'd1000, 12'd800, 2);
    send(12'd1000, 12'd800, 2);
    send(12'd1000, 12'd800, 2);
    send(12'd1000, 12'd800, 1);
    expect_pos(12'd1000, 12'd800);
    idle(4);

    // en low for one cycle mid-burst, with a strobe that must be ignored.
    send(12'd50, 12'd50, 1);
    send(12'd50, 12'd50, 1);
    send(12'd50, 12'd50, 1);
    @(negedge clk);
    en = 1'b0; raw_ready = 1'b1; raw_x = 12'd50; raw_y = 12'd50;
    @(negedge clk);
    en = 1'b1; raw_ready = 1'b0;
    check("pen_after_en_low", 32'(pen_down), 32'd0);
    send(12'd300, 12'd300, 1);
    send(12'd300, 12'd300, 1);
    send(12'd300, 12'd300, 1);
    send(12'd300, 12'd300, 1);
    expect_pos(12'd300, 12'd300);
    idle(4);

    // Strobe during CHECK is dropped; the next output needs 4 new samples.
    send(12'd700, 12'd700, 0);
    send(12'd700, 12'd700, 0);
    send(12'd700, 12'd700, 0);
    send(12'd700, 12'd700, 0);
    expect_pos(12'd700, 12'd700);
    send(12'd0, 12'd0, 1);
    idle(3);
    send(12'd800, 12'd800, 1);
    send(12'd800, 12'd800, 1);
    send(12'd800, 12'd800, 1);
    idle(4);
    send(12'd800, 12'd800, 1);
    expect_pos(12'd800, 12'd800);
    idle(4);

    // Reset mid-burst: outputs return to reset values, burst is dropped.
    send(12'd900, 12'd900, 1);
    send(12'd900, 12'd900, 1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_pos_ready", 32'(pos_ready), 32'd0);
    check("mid_rst_pen_down", 32'(pen_down), 32'd0);
    check("mid_rst_x_pos", 32'(x_pos), 32'd0);
    check("mid_rst_y_pos", 32'(y_pos), 32'd0);
    reset = 1'b0;
    send(12'd900, 12'd900, 1);
    send(12'd900, 12'd900, 1);
    idle(8);

    check("pending_expectations", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/touch_filter.md
# touch_filter

Conditioning stage between the LT24 touchscreen ADC driver and the painter. Collects bursts of raw 12-bit X/Y conversions, rejects noisy bursts whose spread exceeds a threshold, and emits one averaged position with a single-cycle `pos_ready` pulse per accepted burst. Also tracks pen contact with a pen-up timeout, so stale partial bursts never reach the painter.

## Interface
Parameters:
- `N_AVG`, default 4: samples per burst; power of two, 2..16.
- `MAX_SPREAD`, default 12'd64: maximum allowed (max − min) per axis within a burst, inclusive.
- `PENUP_TIMEOUT`, default 24'd500000: idle cycles without a raw sample before the pen is considered lifted (10 ms at 50 MHz).

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `en`  in  1  filter enable; low flushes the current burst.
- `raw_ready`  in  1  single-cycle strobe from the touchscreen driver; `raw_x`/`raw_y` valid this cycle.
- `raw_x`  in  12  raw ADC X.
- `raw_y`  in  12  raw ADC Y.
- `pos_ready`  out  1  single-cycle pulse; averaged position valid.
- `x_pos`  out  12  averaged X, held until the next accepted burst.
- `y_pos`  out  12  averaged Y, held until the next accepted burst.
- `pen_down`  out  1  high from the first accepted burst until pen-up timeout or `en` low.

## Operation
- The FSM has four states.
  - IDLE: no burst in progress. `raw_ready && en` loads the sample as the first sample of a burst: sum = sample, min = max = sample, count = 1. Go to ACCUM, or to CHECK if `N_AVG` is 1.
  - ACCUM: each `raw_ready` adds the sample to the sums, updates per-axis min/max, and increments count. When count reaches `N_AVG`, go to CHECK.
  - CHECK: one cycle. If (xmax − xmin) ≤ `MAX_SPREAD` and (ymax − ymin) ≤ `MAX_SPREAD`, latch x_pos = xsum >> log2(N_AVG) and y_pos = ysum >> log2(N_AVG), then go to OUTPUT. Otherwise discard the burst and go to IDLE.
  - OUTPUT: one cycle. `pos_ready` = 1 and `pen_down` is set. Go to IDLE.
- Arithmetic:
  - Sums are 12 + log2(N_AVG) bits wide and cannot overflow.
  - The average truncates, with no rounding.
  - Spread is computed as an unsigned 12-bit difference.
- `raw_ready` arriving in CHECK or OUTPUT is dropped; it does not start the next burst.
- Pen-up timer:
  - 24-bit counter, cleared on every `raw_ready`, otherwise incremented, saturating at `PENUP_TIMEOUT`.
  - On reaching `PENUP_TIMEOUT`: `pen_down` goes to 0, and if in ACCUM the partial burst is discarded and the FSM returns to IDLE.
  - `raw_ready` in the same cycle as the timeout: `raw_ready` wins. The counter clears and the sample is accumulated.
- `en` low, in any state:
  - Next state is IDLE, accumulators are cleared, and `pos_ready` is 0.
  - `pen_down` goes to 0.
  - `x_pos`/`y_pos` hold their values.
  - `raw_ready` is ignored while `en` is low.

## Timing
- Reset values:
  - State IDLE; `pos_ready` = 0, `pen_down` = 0, `x_pos` = 0, `y_pos` = 0.
  - Sums, min/max and count are 0; the timeout counter is 0.
- Reset mid-burst drops the burst with no output.
- Latency: the Nth sample is strobed at cycle t. CHECK runs at t+1. `pos_ready` is high at t+2, with `x_pos`/`y_pos` already valid at t+2.
- `pos_ready` is never high for two consecutive cycles.
- Minimum burst-to-burst output spacing is `N_AVG` + 2 cycles.
- `pen_down` rises in the same cycle as the first `pos_ready`.
- `pen_down` falls on the cycle after the counter reaches `PENUP_TIMEOUT`, or on the cycle after `en` is sampled low.
- All outputs are registered.

## Test plan
- Identical samples: 4 strobes of (100, 200), 3 idle cycles apart → one `pos_ready` pulse 2 cycles after the 4th strobe, with x_pos = 100, y_pos = 200, and `pen_down` rising with it.
- Averaging: X = 100, 102, 104, 106 and Y = 50, 50, 51, 51 → x_pos = 103, y_pos = 50 (truncated).
- Spread boundary: X = 0, 0, 0, 64 → accepted, x_pos = 16. X = 0, 0, 0, 65 → no `pos_ready`, and the previous x_pos/y_pos are retained.
- Timeout: 2 samples, then `PENUP_TIMEOUT` idle cycles → burst discarded and `pen_down` = 0. The next 4 valid samples produce a fresh average unaffected by the 2 stale samples.
- `en` low mid-burst: 3 samples, `en` low for 1 cycle, then 4 samples of 300 → exactly one output, x_pos = 300.
- Drop window and reset: a strobe during CHECK is not counted, verified by the next output needing 4 new samples. `reset` asserted in ACCUM → all outputs return to their reset values and no pulse is emitted.
